// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops words from a fifo and sends each one as an async serial
// frame (start bit, data LSB first, stop bits). Back-to-back words are sent
// gapless by popping in the last stop-bit cycle.
module fifo_serial_tx #(
   parameter int unsigned BitWidth     = 8,
   parameter int unsigned ClocksPerBit = 16,  // minimum 2
   parameter int unsigned StopBits     = 1    // 1 or 2
) (
   input  logic                i_clock,
   input  logic                i_reset,        // synchronous, active-low
   input  logic                i_enable,
   input  logic                i_fifo_empty,
   input  logic [BitWidth-1:0] i_fifo_pop_data,
   output logic                o_fifo_pop,
   output logic                o_txd,
   output logic                o_busy,
   output logic                o_frame_done
);

   localparam int unsigned CntW = (ClocksPerBit > 1) ? $clog2(ClocksPerBit) : 1;
   localparam int unsigned IdxW = (BitWidth > 1) ? $clog2(BitWidth) : 1;
   localparam logic [CntW-1:0] BaudLoad = CntW'(ClocksPerBit - 1);
   localparam logic [IdxW-1:0] LastIdx  = IdxW'(BitWidth - 1);
   localparam logic            LastStop = (StopBits == 2);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e              r_state;
   logic [BitWidth-1:0] r_shift;
   logic [CntW-1:0]     r_baud;
   logic [IdxW-1:0]     r_bit_idx;
   logic                r_stop_idx;
   logic                r_txd;
   logic                r_frame_done;

   logic w_baud_zero;
   logic w_last_stop;
   logic w_pop;
   logic w_frame_done_next;

   // Bit-boundary and pop decode from current state
   always_comb begin
      w_baud_zero = (r_baud == '0);
      w_last_stop = (r_state == StStop) && w_baud_zero && (r_stop_idx == LastStop);
      w_pop       = i_reset & i_enable & ~i_fifo_empty &
                    ((r_state == StIdle) | w_last_stop);
      // One cycle ahead of the last stop cycle so the registered pulse lands on it;
      // reload is always >= 1, so baud==1 is reached in every stop bit.
      w_frame_done_next = (r_state == StStop) && (r_baud == CntW'(1)) &&
                          (r_stop_idx == LastStop);
   end

   // Frame FSM with baud counter, shifter and registered line/pulse outputs
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state      <= StIdle;
         r_shift      <= '0;
         r_baud       <= BaudLoad;
         r_bit_idx    <= '0;
         r_stop_idx   <= 1'b0;
         r_txd        <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_frame_done_next;
         if ((r_state != StIdle) && !w_baud_zero) begin
            r_baud <= r_baud - CntW'(1);
         end
         case (r_state)
            StIdle: begin
               if (w_pop) begin
                  r_shift <= i_fifo_pop_data;
                  r_baud  <= BaudLoad;
                  r_state <= StStart;
                  r_txd   <= 1'b0;
               end
            end
            StStart: begin
               if (w_baud_zero) begin
                  r_state   <= StData;
                  r_txd     <= r_shift[0];
                  r_shift   <= r_shift >> 1;
                  r_bit_idx <= '0;
                  r_baud    <= BaudLoad;
               end
            end
            StData: begin
               if (w_baud_zero) begin
                  r_baud <= BaudLoad;
                  if (r_bit_idx == LastIdx) begin
                     r_state    <= StStop;
                     r_txd      <= 1'b1;
                     r_stop_idx <= 1'b0;
                  end else begin
                     r_bit_idx <= r_bit_idx + IdxW'(1);
                     r_txd     <= r_shift[0];
                     r_shift   <= r_shift >> 1;
                  end
               end
            end
            StStop: begin
               if (w_baud_zero) begin
                  r_baud <= BaudLoad;
                  if (r_stop_idx == LastStop) begin
                     // Gapless hand-off: next word starts right after the last stop cycle
                     if (w_pop) begin
                        r_shift <= i_fifo_pop_data;
                        r_state <= StStart;
                        r_txd   <= 1'b0;
                     end else begin
                        r_state <= StIdle;
                     end
                  end else begin
                     r_stop_idx <= 1'b1;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_fifo_pop   = w_pop;
   assign o_txd        = r_txd;
   assign o_busy       = (r_state != StIdle);
   assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: bench-side fifo models feed two instances
// (1 and 2 stop bits); a monitor decodes dut1 frames against a scoreboard.
module tb_fifo_serial_tx;

   localparam int unsigned Cpb = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;
   logic en1 = 1'b1;
   logic en2 = 1'b1;

   // Bench fifo models: array plus head/tail pointers
   logic [7:0] mem1 [0:63];
   logic [7:0] mem2 [0:63];
   int head1 = 0, tail1 = 0, head2 = 0, tail2 = 0;
   logic       fe1, fe2;
   logic [7:0] fd1, fd2;
   assign fe1 = (head1 == tail1);
   assign fe2 = (head2 == tail2);
   assign fd1 = mem1[head1[5:0]];
   assign fd2 = mem2[head2[5:0]];

   logic pop1, txd1, busy1, done1;
   logic pop2, txd2, busy2, done2;

   fifo_serial_tx #(.BitWidth(8), .ClocksPerBit(Cpb), .StopBits(1)) dut1 (
      .i_clock        (clk),
      .i_reset        (rst_n),
      .i_enable       (en1),
      .i_fifo_empty   (fe1),
      .i_fifo_pop_data(fd1),
      .o_fifo_pop     (pop1),
      .o_txd          (txd1),
      .o_busy         (busy1),
      .o_frame_done   (done1)
   );

   fifo_serial_tx #(.BitWidth(8), .ClocksPerBit(Cpb), .StopBits(2)) dut2 (
      .i_clock        (clk),
      .i_reset        (rst_n),
      .i_enable       (en2),
      .i_fifo_empty   (fe2),
      .i_fifo_pop_data(fd2),
      .o_fifo_pop     (pop2),
      .o_txd          (txd2),
      .o_busy         (busy2),
      .o_frame_done   (done2)
   );

   // Fifo consumes the head word at the edge where pop is high
   always @(posedge clk) begin
      if (pop1) head1 <= head1 + 1;
      if (pop2) head2 <= head2 + 1;
   end

   int checks = 0;
   int errors = 0;
   int frames1 = 0;
   logic [7:0] exp1 [$];
   logic [9:0] last_bits = '0;

   function automatic void chk(input string name, input logic [31:0] got,
                               input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", name, got, req, $time);
      end
   endfunction

   task automatic push1(input logic [7:0] w);
      mem1[tail1[5:0]] = w;
      tail1++;
      exp1.push_back(w);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy1 && n < 200) begin
         cyc(1);
         n++;
      end
      chk(name, busy1, 0);
   endtask

   // Monitor: captures each dut1 frame from its pop and compares with the scoreboard
   initial begin : monitor
      logic go, have, wave_ok, done_ok, busy_ok, aborted, expbit;
      logic [7:0] w;
      logic [9:0] bits;
      int k;
      go = 1'b0;
      forever begin
         if (!go) begin
            @(negedge clk);
            if (pop1 && (fe1 || !en1 || !rst_n)) chk("pop_guard", pop1, 0);
            go = rst_n && pop1;
         end else begin
            go      = 1'b0;
            have    = (exp1.size() > 0);
            w       = have ? exp1[0] : 8'h00;
            if (!have) chk("unexpected_pop", 0, 1);
            wave_ok = 1'b1;
            done_ok = 1'b1;
            busy_ok = 1'b1;
            aborted = 1'b0;
            bits    = '0;
            for (int c = 0; c < 40; c++) begin
               @(negedge clk);
               if (!rst_n) begin
                  aborted = 1'b1;
                  break;
               end
               k = c / 4;
               if (k == 0) expbit = 1'b0;
               else if (k == 9) expbit = 1'b1;
               else expbit = w[k-1];
               if (txd1 !== expbit) wave_ok = 1'b0;
               if (c % 4 == 2) bits[k] = txd1;
               if (done1 !== (c == 39)) done_ok = 1'b0;
               if (busy1 !== 1'b1) busy_ok = 1'b0;
               if (c == 39) begin
                  chk($sformatf("gapless_pop_%02h", w), pop1, (en1 && !fe1));
                  go = pop1;
               end
            end
            if (!aborted) begin
               chk($sformatf("frame_wave_%02h", w), wave_ok, 1);
               chk($sformatf("frame_done_%02h", w), done_ok, 1);
               chk($sformatf("frame_busy_%02h", w), busy_ok, 1);
               last_bits = bits;
               if (have) void'(exp1.pop_front());
               frames1++;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   // Directed stimulus
   initial begin : stim
      int n;
      logic wave_ok, done_ok, busy_ok, stay_ok;

      // 1. reset held 4 cycles with a word waiting and enable high
      rst_n = 1'b0;
      en1   = 1'b1;
      push1(8'hA5);
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         chk("rst_txd", txd1, 1);
         chk("rst_pop", pop1, 0);
         chk("rst_busy", busy1, 0);
      end

      // 2. single 0xA5 frame after release; start bit one clock after the pop
      rst_n = 1'b1;
      cyc(1);
      chk("t2_busy", busy1, 1);
      chk("t2_start_txd", txd1, 0);
      wait_idle("t2_idle");
      chk("t2_bits", last_bits, 10'b1101001010);
      chk("t2_frames", frames1, 1);

      // 3. three words back-to-back
      push1(8'h05);
      push1(8'h06);
      push1(8'h07);
      cyc(2);
      wait_idle("t3_idle");
      chk("t3_empty", fe1, 1);
      chk("t3_frames", frames1, 4);

      // 5. enable dropped during DATA with another word queued
      push1(8'h3C);
      push1(8'hC3);
      cyc(14);
      en1 = 1'b0;
      wait_idle("t5_idle1");
      cyc(10);
      chk("t5_nopop", pop1, 0);
      chk("t5_held", fe1, 0);
      chk("t5_frames", frames1, 5);
      en1 = 1'b1;
      #1;
      chk("t5_pop", pop1, 1);
      cyc(1);
      chk("t5_start_txd", txd1, 0);
      wait_idle("t5_idle2");
      chk("t5_frames2", frames1, 6);

      // 6. one-cycle reset during the 3rd data bit of 0x11
      push1(8'h11);
      push1(8'h22);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!pop1 && n < 50);
      chk("t6_pop_seen", pop1, 1);
      cyc(13);
      rst_n = 1'b0;
      void'(exp1.pop_front());  // 0x11 is aborted and must never appear
      #1;
      chk("t6_rst_pop", pop1, 0);
      cyc(1);
      chk("t6_rst_txd", txd1, 1);
      chk("t6_rst_busy", busy1, 0);
      rst_n = 1'b1;
      cyc(1);
      chk("t6_restart", busy1, 1);
      wait_idle("t6_idle");
      chk("t6_sb_empty", exp1.size(), 0);
      chk("t6_fifo_empty", fe1, 1);
      chk("t6_frames", frames1, 7);

      // 4. two stop bits, single 0xFF on dut2
      mem2[tail2[5:0]] = 8'hFF;
      tail2++;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!pop2 && n < 50);
      chk("t4_pop_seen", pop2, 1);
      wave_ok = 1'b1;
      done_ok = 1'b1;
      busy_ok = 1'b1;
      for (int c = 0; c < 44; c++) begin
         @(negedge clk);
         if (txd2 !== (c >= 4)) wave_ok = 1'b0;
         if (done2 !== (c == 43)) done_ok = 1'b0;
         if (busy2 !== 1'b1) busy_ok = 1'b0;
      end
      chk("t4_wave", wave_ok, 1);
      chk("t4_done", done_ok, 1);
      chk("t4_busy", busy_ok, 1);
      @(negedge clk);
      chk("t4_end_busy", busy2, 0);
      chk("t4_end_txd", txd2, 1);
      stay_ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (pop2 || txd2 !== 1'b1 || busy2) stay_ok = 1'b0;
      end
      chk("t4_stay_idle", stay_ok, 1);

      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
